// File: rtl/edac_scrub_ctrl.sv
// Background EDAC scrubber: sweeps memory, checks each word through the external
// decoder/encoder, writes back corrected codewords and counts uncorrectable words.
module edac_scrub_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       dec_din,
    output logic              dec_en,
    input  logic [31:0]       dec_dout,
    input  logic              dec_valid,
    output logic [7:0]        enc_din,
    input  logic [31:0]       enc_dout,
    output logic              busy,
    output logic              sweep_done,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic [ADDR_W-1:0] last_err_addr
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RREQ, S_RWAIT, S_CHECK, S_WREQ, S_NEXT, S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   corr_q, corr_d;
    logic [CNT_W-1:0]   uncorr_q, uncorr_d;
    logic [ADDR_W-1:0]  lerr_q, lerr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               dec_ok;

    // The all-ones decoder word is its failure marker, so it is never a good decode.
    assign dec_ok = dec_valid && (dec_dout != 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            word_q   <= '0;
            wdata_q  <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
            lerr_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            lerr_q   <= lerr_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        corr_d     = corr_q;
        uncorr_d   = uncorr_q;
        lerr_d     = lerr_q;
        gap_d      = gap_q;
        mem_req    = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        dec_en     = 1'b0;
        sweep_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    addr_d  = '0;
                    state_d = S_RREQ;
                end
            end
            S_RREQ: begin
                mem_req = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mem_gnt) begin
                    mem_rd_en = 1'b1;
                    state_d   = S_RWAIT;
                end
            end
            S_RWAIT: begin
                word_d  = mem_rdata;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                dec_en = 1'b1;
                if (!dec_ok) begin
                    if (uncorr_q != '1) uncorr_d = uncorr_q + CNT_W'(1);
                    lerr_d  = addr_q;
                    state_d = S_NEXT;
                end else if (enc_dout == word_q) begin
                    state_d = S_NEXT;
                end else begin
                    wdata_d = enc_dout;
                    if (corr_q != '1) corr_d = corr_q + CNT_W'(1);
                    state_d = S_WREQ;
                end
            end
            S_WREQ: begin
                // A pending write always completes; abort is not honoured here.
                mem_req = 1'b1;
                if (mem_gnt) begin
                    mem_wr_en = 1'b1;
                    state_d   = S_NEXT;
                end
            end
            S_NEXT: begin
                gap_d = '0;
                if (addr_q == LAST_ADDR) begin
                    sweep_done = 1'b1;
                    if (continuous && !abort) begin
                        addr_d  = '0;
                        state_d = (GAP_CYCLES == 0) ? S_RREQ : S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = (GAP_CYCLES == 0) ? S_RREQ : S_GAP;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = S_RREQ;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset drops any access in flight, including a granted write.
        if (rst) begin
            mem_req   = 1'b0;
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign dec_din       = word_q;
    assign enc_din       = dec_dout[7:0];
    assign busy          = (state_q != S_IDLE);
    assign corr_cnt      = corr_q;
    assign uncorr_cnt    = uncorr_q;
    assign last_err_addr = lerr_q;

endmodule
